// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-architecture CPU control path: opcodes,
// instruction field positions, sequencer states and opcode classification.
package cpu_pkg;

    localparam int unsigned OP_HI = 31;
    localparam int unsigned OP_LO = 27;
    localparam int unsigned RA_HI = 26;
    localparam int unsigned RA_LO = 23;
    localparam int unsigned RB_HI = 22;
    localparam int unsigned RB_LO = 19;
    localparam int unsigned RC_HI = 18;
    localparam int unsigned RC_LO = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    typedef enum logic [2:0] {RESET_S, T0, T1, T2, T3, T4, T5, HALT_S} state_t;

    // Execute-phase shape of an instruction; ClsShort finishes in T3.
    typedef enum logic [2:0] {
        ClsAlu, ClsMulDiv, ClsUnary, ClsLd, ClsSt, ClsShort, ClsHalt
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: return ClsAlu;
            OP_MUL, OP_DIV:                 return ClsMulDiv;
            OP_NEG, OP_NOT:                 return ClsUnary;
            OP_LD:                          return ClsLd;
            OP_ST:                          return ClsSt;
            OP_HALT:                        return ClsHalt;
            default:                        return ClsShort;
        endcase
    endfunction

endpackage

// File: rtl/gpr_select_encode.sv
// Selects one of the Ra/Rb/Rc instruction fields and turns it into one-hot
// GPR load/drive strobes.
module gpr_select_encode
    import cpu_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned REGISTERS = 16
) (
    input  logic [BITS-1:0]      IRVal,
    input  logic                 Gra,
    input  logic                 Grb,
    input  logic                 Grc,
    input  logic                 Rin,
    input  logic                 Rout,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout
);

    logic [3:0]           sel;
    logic [REGISTERS-1:0] onehot;
    logic                 unused_ir;

    assign unused_ir = ^{IRVal[BITS-1:RA_HI+1], IRVal[RC_LO-1:0]};

    always_comb begin
        sel = 4'd0;
        if (Gra) begin
            sel = IRVal[RA_HI:RA_LO];
        end else if (Grb) begin
            sel = IRVal[RB_HI:RB_LO];
        end else if (Grc) begin
            sel = IRVal[RC_HI:RC_LO];
        end
        onehot = REGISTERS'(1) << sel;
        GPRin  = Rin  ? onehot : '0;
        GPRout = Rout ? onehot : '0;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fixed three-step fetch, per-opcode execute steps,
// Moore control strobes decoded from the state register and IRVal.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned REGISTERS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stop,
    input  logic [BITS-1:0]      IRVal,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 HILOin,
    output logic                 MDRin,
    output logic                 OUTPUTin,
    output logic                 Read,
    output logic                 Write,
    output logic                 INPUTout,
    output logic                 MDRout,
    output logic                 HILOout,
    output logic                 RZout,
    output logic                 PCout,
    output logic                 BAout,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 IncPC,
    output logic                 run,
    output logic [BITS-1:0]      instr_count
);

    state_t     state;
    logic [4:0] op;
    op_class_t  cls;
    logic       done;
    logic       gra, grb, grc, rin, rout;

    assign op  = IRVal[OP_HI:OP_LO];
    assign cls = op_class(op);
    assign run = (state != RESET_S) && (state != HALT_S);

    // Last execute step of a non-halt instruction.
    assign done = (state == T5) ||
                  (state == T4 && cls == ClsUnary) ||
                  (state == T3 && cls == ClsShort);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RESET_S;
            instr_count <= '0;
        end else if (done) begin
            instr_count <= instr_count + BITS'(1);
            state       <= stop ? HALT_S : T0;
        end else begin
            case (state)
                RESET_S: state <= T0;
                T0:      state <= T1;
                T1:      state <= T2;
                T2:      state <= T3;
                T3:      state <= (cls == ClsHalt) ? HALT_S : T4;
                T4:      state <= T5;
                default: state <= state;
            endcase
        end
    end

    always_comb begin
        {PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin} = '0;
        {Read, Write, INPUTout, MDRout, HILOout, RZout, PCout, BAout} = '0;
        {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC} = '0;
        {gra, grb, grc, rin, rout} = '0;
        case (state)
            T0: {PCout, MARin, IncPC, RZin} = '1;
            T1: {RZout, PCin, Read, MDRin} = '1;
            T2: {MDRout, IRin} = '1;
            T3: begin
                case (cls)
                    ClsAlu, ClsMulDiv: {grb, rout, RYin} = '1;
                    ClsUnary: begin
                        {grb, rout, RZin} = '1;
                        NEGATE = (op == OP_NEG);
                        NOT    = (op == OP_NOT);
                    end
                    ClsLd, ClsSt: {grb, rout, BAout, MARin} = '1;
                    ClsShort: begin
                        case (op)
                            OP_IN:   {INPUTout, gra, rin} = '1;
                            OP_OUT:  {gra, rout, OUTPUTin} = '1;
                            OP_JR:   {gra, rout, PCin} = '1;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    ClsAlu, ClsMulDiv: begin
                        {grc, rout, RZin} = '1;
                        ADD = (op == OP_ADD);
                        SUB = (op == OP_SUB);
                        AND = (op == OP_AND);
                        OR  = (op == OP_OR);
                        ROR = (op == OP_ROR);
                        ROL = (op == OP_ROL);
                        SHR = (op == OP_SHR);
                        SHL = (op == OP_SHL);
                        MUL = (op == OP_MUL);
                        DIV = (op == OP_DIV);
                    end
                    ClsUnary: {RZout, gra, rin} = '1;
                    ClsLd:    {Read, MDRin} = '1;
                    ClsSt:    {gra, rout, MDRin} = '1;
                    default: ;
                endcase
            end
            T5: begin
                case (cls)
                    ClsAlu:    {RZout, gra, rin} = '1;
                    ClsMulDiv: {RZout, HILOin} = '1;
                    ClsLd:     {MDRout, gra, rin} = '1;
                    ClsSt:     {MDRout, Write} = '1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    gpr_select_encode #(
        .BITS     (BITS),
        .REGISTERS(REGISTERS)
    ) u_gpr_select_encode (
        .IRVal (IRVal),
        .Gra   (gra),
        .Grb   (grb),
        .Grc   (grc),
        .Rin   (rin),
        .Rout  (rout),
        .GPRin (GPRin),
        .GPRout(GPRout)
    );

endmodule
